// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end of the DSP core. It holds the program counter,
// issues single-cycle synchronous reads to program memory, and buffers the
// returned words in a small prefetch queue. Decode takes words from the queue
// over a valid/ready handshake. A taken branch or jump from execute
// (redirect) flushes all wrong-path words and restarts fetch at the target.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   defined   - a response that arrives while the queue is empty is presented
//               to decode in the same cycle (fetch-to-valid latency 1). It is
//               enqueued only if decode does not take it.
//   undefined - decode always sees the registered queue head
//               (fetch-to-valid latency 2).
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous active-low reset
//   imem_en      program memory read strobe
//   imem_addr    program memory word address
//   imem_rdata   read data, valid one cycle after imem_en
//   redirect     taken branch/jump pulse from execute (highest priority)
//   redirect_pc  redirect target, sampled when redirect is high
//   instr_valid  head of the queue holds a valid instruction
//   instr        head instruction word
//   instr_pc     address the head instruction was fetched from
//   instr_ready  decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;

    // Read issued last cycle; its data is on imem_rdata now.
    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               q_empty;
    logic               rsp_live;
    logic               byp;
    logic               take;
    logic               q_pop;
    logic               q_push;
    logic [CNT_W-1:0]   occ;
    logic               issue;

    assign q_empty = (count == '0);

    // A response landing in the redirect cycle is wrong-path: it is dropped
    // here and never reaches the queue or the bypass path.
    assign rsp_live = vld_p1 && !redirect;

`ifdef FETCH_BYPASS_EN
    assign byp = rsp_live && q_empty;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid = !q_empty || byp;
    assign instr       = byp ? imem_rdata : q_instr[rd_ptr];
    assign instr_pc    = byp ? addr_p1    : q_pc[rd_ptr];

    assign take   = instr_valid && instr_ready;
    assign q_pop  = take && !q_empty;
    // A bypassed word that decode takes immediately never occupies a slot.
    assign q_push = rsp_live && !(byp && instr_ready);

    // Slots committed after this edge without a new issue: current entries
    // plus the arriving response, minus whatever decode takes this cycle.
    assign occ = count + CNT_W'(rsp_live) - CNT_W'(take);

    assign issue = reset && !redirect && (state != IDLE) &&
                   (occ < CNT_W'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = pc;

    // ---- issue stage (p0) -> response stage (p1) -> queue ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect) begin
            // No read is issued this cycle, so nothing is left in flight.
            state  <= FLUSH;
            pc     <= redirect_pc;
            vld_p1 <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     state <= RUN;
                FLUSH:   state <= RUN;
                default: state <= IDLE;
            endcase

            vld_p1 <= issue;
            if (issue) begin
                addr_p1 <= pc;
                pc      <= pc + ADDR_W'(1);
            end

            if (q_push) begin
                q_instr[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]    <= addr_p1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(q_push) - CNT_W'(q_pop);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam int          ADDR_W   = 16;
    localparam int          INSTR_W  = 16;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    // Scoreboard: redirect targets queued by stimulus, consumed by the monitor.
    logic [15:0] seg_q [$];
    logic [15:0] exp_pc = 16'h0000;
    bit          armed = 1'b0;
    int          accepted = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    // Program memory: one-cycle synchronous read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        seg_q.push_back(t);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < maxc);
        check("wait_valid", instr_valid, 1);
    endtask

    // Monitor / reference model: decode must see a contiguous run of
    // addresses starting at RESET_PC or at the latest redirect target, each
    // carrying mem[address]; a held head must not change.
    initial begin
        bit          prev_hold;
        logic [15:0] prev_instr;
        logic [15:0] prev_pc;
        prev_hold  = 1'b0;
        prev_instr = '0;
        prev_pc    = '0;
        forever begin
            @(negedge clk);
            if (armed && reset && instr_valid && instr_ready) begin
                check("stream_pc", instr_pc, exp_pc);
                check("stream_instr", instr, mem[exp_pc]);
                exp_pc = exp_pc + 16'd1;
                accepted++;
            end
            if (prev_hold) begin
                check("hold_valid", instr_valid, 1);
                check("hold_instr", instr, prev_instr);
                check("hold_pc", instr_pc, prev_pc);
            end
            prev_hold  = armed && reset && !redirect && instr_valid && !instr_ready;
            prev_instr = instr;
            prev_pc    = instr_pc;
            if (redirect) begin
                if (seg_q.size() != 0) begin
                    exp_pc = seg_q.pop_front();
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL seg_queue: redirect seen with no target queued");
                end
            end
            if (!reset) begin
                exp_pc = RESET_PC;
                armed  = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int issued;
        int acc0;
        logic [31:0] v;

        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0]        = 16'h1111;
        mem[1]        = 16'h2222;
        mem[2]        = 16'h3333;
        mem[3]        = 16'h4444;
        mem[16'h0040] = 16'hBEEF;
        mem[16'hFFFF] = 16'hAAAA;

        // Reset state and first fill with decode always ready
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("rst_imem_en", imem_en, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_fetch", imem_en, 0);
        @(negedge clk);
        check("first_fetch_en", imem_en, 1);
        check("first_fetch_addr", imem_addr, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 8);
        check("fetch_latency", n, LAT);
        for (int i = 0; i < 4; i++) begin
            v = 32'h1111 * (i + 1);
            check("fill_valid", instr_valid, 1);
            check("fill_instr", instr, v);
            check("fill_pc", instr_pc, i);
            @(negedge clk);
        end

        // Decode stalled: queue fills to DEPTH and fetch stops
        tick();
        instr_ready = 1'b0;
        reset       = 1'b0;
        tick();
        reset  = 1'b1;
        issued = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_en) issued++;
        end
        check("full_issued", issued, DEPTH);
        check("full_no_fetch", imem_en, 0);
        check("full_valid", instr_valid, 1);
        check("full_instr", instr, 16'h1111);
        check("full_pc", instr_pc, 0);
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v = 32'h1111 * (i + 1);
            check("drain_valid", instr_valid, 1);
            check("drain_instr", instr, v);
        end

        // Redirect with wrong-path words queued and in flight
        tick();
        instr_ready = 1'b0;
        reset       = 1'b0;
        tick();
        reset = 1'b1;
        repeat (6) @(negedge clk);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        do_redirect(16'h0040);
        @(negedge clk);
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        wait_valid(10, n);
        check("redirect_penalty", n, 1 + LAT);
        check("redirect_instr", instr, 16'hBEEF);
        check("redirect_pc", instr_pc, 16'h0040);

        // Reset mid-stream while pc=5 is being fetched
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_en && imem_addr == 16'h0005) && n < 20);
        check("reach_pc5", imem_addr, 16'h0005);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", instr_valid, 0);
        check("midrst_instr", instr, 0);
        check("midrst_pc", instr_pc, 0);
        check("midrst_imem_en", imem_en, 0);
        wait_valid(10, n);
        check("restart_pc", instr_pc, 16'h0000);
        check("restart_instr", instr, 16'h1111);

        // PC wrap 0xFFFF -> 0x0000
        tick();
        reset  = 1'b0;
        mem[0] = 16'h5555;
        tick();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        do_redirect(16'hFFFF);
        tick();
        redirect = 1'b0;
        wait_valid(10, n);
        check("wrap_pc0", instr_pc, 16'hFFFF);
        check("wrap_instr0", instr, 16'hAAAA);
        @(negedge clk);
        check("wrap_valid1", instr_valid, 1);
        check("wrap_pc1", instr_pc, 16'h0000);
        check("wrap_instr1", instr, 16'h5555);

        // Randomized traffic: ready, redirects and occasional resets
        acc0 = accepted;
        tick();
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 99) < 70);
            redirect    = 1'b0;
            reset       = 1'b1;
            if ($urandom_range(0, 99) < 4)
                do_redirect(16'h1000 + 16'($urandom_range(0, 16'h0E00)));
            if ($urandom_range(0, 199) == 0) reset = 1'b0;
            tick();
        end
        redirect    = 1'b0;
        reset       = 1'b1;
        instr_ready = 1'b1;
        repeat (5) tick();
        check("random_progress", (accepted - acc0) > 300, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
